ram32_arbiter: RTL and testbench

RAM32_ARBITER -- requirements
Module: ram32_arbiter

---
 rtl/ram32_arbiter_if.sv | 38 +++
 rtl/ram32_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram32_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram32_arbiter_if.sv
// ram32_arbiter_if: requester and RAM-side signals of the two-port RAM arbiter.
//   Parameters : ADDR_W (RAM address width), DATA_W (RAM data width)
//   Requesters : req0/1, wr0/1, addr0/1, wdata0/1 in; gnt0/1, ack0/1, rdata out
//   RAM side   : ram_wr_rd, ram_addr, ram_din out; ram_dout in
//   slave      : view used by the arbiter
//   master     : view used by the environment (requesters + RAM)
interface ram32_arbiter_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8
);
   logic              req0;
   logic              req1;
   logic              wr0;
   logic              wr1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata;
   logic              ram_wr_rd;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   modport slave (
      input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_dout,
      output gnt0, gnt1, ack0, ack1, rdata, ram_wr_rd, ram_addr, ram_din
   );

   modport master (
      output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_dout,
      input  gnt0, gnt1, ack0, ack1, rdata, ram_wr_rd, ram_addr, ram_din
   );
endinterface

// File: rtl/ram32_arbiter.sv
// ram32_arbiter: arbitrates two requesters onto one synchronous single-port RAM.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ram32_arbiter_if.slave (requester handshake, rdata, RAM port)
// Writes take IDLE->WR->DONE, reads IDLE->RD->CAP->DONE; ack pulses in DONE.
// Build option: define RAM32_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise requester 0 has fixed priority.
module ram32_arbiter #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8
) (
   input logic            clk,
   input logic            rst,
   ram32_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD   = 3'd2,
      CAP  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Request payload presented by one requester
   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_fields_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_din_q, ram_din_d;
   logic              ram_wr_rd_q, ram_wr_rd_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   req_fields_t       req0_f;
   req_fields_t       req1_f;
   req_fields_t       sel_f;
   logic              win_c;
   logic              busy_c;

   assign req0_f = {bus.wr0, bus.addr0, bus.wdata0};
   assign req1_f = {bus.wr1, bus.addr1, bus.wdata1};

`ifdef RAM32_ARB_RR_EN
   // rr_q = 1 means requester 1 wins the next tie
   logic rr_q, rr_d;

   assign win_c = (bus.req0 && bus.req1) ? rr_q : !bus.req0;

   // Point away from whoever was just granted
   always_comb begin
      rr_d = rr_q;
      if (state_q == IDLE && (bus.req0 || bus.req1)) begin
         rr_d = !win_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   // Fixed priority: requester 0 wins whenever it asks
   assign win_c = !bus.req0;
`endif

   // Next state, latched transaction fields and registered-output values
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      sel_f      = req0_f;

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               sel_f      = win_c ? req1_f : req0_f;
               owner_d    = win_c;
               ram_addr_d = sel_f.addr;
               ram_din_d  = sel_f.wdata;
               state_d    = sel_f.wr ? WR : RD;
            end
         end
         WR:      state_d = DONE;
         RD:      state_d = CAP;
         CAP:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered copies of the decode of the next state
      busy_c      = (state_d != IDLE);
      ram_wr_rd_d = (state_d == WR);
      gnt0_d      = busy_c && !owner_d;
      gnt1_d      = busy_c && owner_d;
      ack0_d      = (state_d == DONE) && !owner_d;
      ack1_d      = (state_d == DONE) && owner_d;

      // RAM output is valid during CAP; hold otherwise
      rdata_d     = (state_q == CAP) ? bus.ram_dout : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         ram_wr_rd_q <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
         ram_wr_rd_q <= ram_wr_rd_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.rdata     = rdata_q;
   assign bus.ram_wr_rd = ram_wr_rd_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_din   = ram_din_q;

endmodule

// File: tb/tb_ram32_arbiter.sv
// tb_ram32_arbiter: randomized self-checking bench for ram32_arbiter.
// Holds a 32-entry RAM for the DUT to drive, plus a scoreboard of expected
// RAM contents and expected rdata used to judge every transaction.
module tb_ram32_arbiter;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram32_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram32_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Synchronous RAM: write on edge, read data one cycle after address
   logic [DW-1:0] mem [32];
   always @(posedge clk) begin
      if (bus.ram_wr_rd) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
   end

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] sb [32];
   logic [DW-1:0] exp_rdata;

   function automatic logic gnt_of(input int who);
      return (who == 0) ? bus.gnt0 : bus.gnt1;
   endfunction

   function automatic logic ack_of(input int who);
      return (who == 0) ? bus.ack0 : bus.ack1;
   endfunction

   task automatic drive_req(input int who, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      if (who == 0) begin
         bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
      end else begin
         bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
      end
   endtask

   // Drop a request and scramble its fields; the DUT must not care
   task automatic clear_req(input int who);
      if (who == 0) begin
         bus.req0 = 1'b0; bus.wr0 = 1'($urandom);
         bus.addr0 = AW'($urandom); bus.wdata0 = DW'($urandom);
      end else begin
         bus.req1 = 1'b0; bus.wr1 = 1'($urandom);
         bus.addr1 = AW'($urandom); bus.wdata1 = DW'($urandom);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_req(0);
      clear_req(1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_rdata = '0;
   endtask

   // One isolated transaction from an idle DUT, checked against the model
   task automatic run_txn(input int who, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit drop_early);
      int  lat;
      bit  seen;
      lat  = wr ? 2 : 3;
      seen = 1'b0;
      drive_req(who, wr, a, d);
      for (int k = 1; k <= 8 && !seen; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            checks++;
            if (gnt_of(who) !== 1'b1 || bus.ram_wr_rd !== wr || bus.ram_addr !== a) begin
               errors++;
               $display("FAIL txn_drive who=%0d: gnt=%b wr_rd=%b addr=%0d, want gnt=1 wr_rd=%b addr=%0d",
                        who, gnt_of(who), bus.ram_wr_rd, bus.ram_addr, wr, a);
            end
            if (wr) begin
               checks++;
               if (bus.ram_din !== d) begin
                  errors++;
                  $display("FAIL txn_din: got %h want %h", bus.ram_din, d);
               end
            end
            if (drop_early) clear_req(who);
         end
         checks++;
         if (gnt_of(1 - who) !== 1'b0 || ack_of(1 - who) !== 1'b0) begin
            errors++;
            $display("FAIL txn_other who=%0d k=%0d: other gnt=%b ack=%b, want 0 0",
                     who, k, gnt_of(1 - who), ack_of(1 - who));
         end
         if (ack_of(who) === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (k !== lat) begin
               errors++;
               $display("FAIL txn_latency who=%0d wr=%b: ack at %0d want %0d", who, wr, k, lat);
            end
            if (wr) sb[a] = d;
            else exp_rdata = sb[a];
            checks++;
            if (bus.rdata !== exp_rdata) begin
               errors++;
               $display("FAIL txn_rdata who=%0d wr=%b addr=%0d: got %h want %h",
                        who, wr, a, bus.rdata, exp_rdata);
            end
         end
      end
      if (!seen) begin
         errors++;
         $display("FAIL txn_timeout who=%0d: no ack within 8 cycles", who);
      end
      clear_req(who);
      @(posedge clk); #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1} !== 4'b0000) begin
         errors++;
         $display("FAIL txn_idle_gap: gnt/ack=%b want 0000",
                  {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1});
      end
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.ram_wr_rd} !== 5'b0 ||
          bus.rdata !== '0 || bus.ram_addr !== '0 || bus.ram_din !== '0) begin
         errors++;
         $display("FAIL reset_state: gnt/ack/wr=%b rdata=%h addr=%h din=%h, want all 0",
                  {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.ram_wr_rd},
                  bus.rdata, bus.ram_addr, bus.ram_din);
      end
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      run_txn(0, 1'b1, AW'(5), 8'hA5, 1'b0);
      run_txn(1, 1'b0, AW'(5), 8'h00, 1'b0);
      checks++;
      if (bus.rdata !== 8'hA5) begin
         errors++;
         $display("FAIL write_read_hold: rdata=%h want a5", bus.rdata);
      end
   endtask

   task automatic test_fill_readback();
      for (int a = 0; a < 32; a++)
         run_txn(a % 2, 1'b1, AW'(a), DW'($urandom), 1'($urandom));
      for (int a = 0; a < 32; a++)
         run_txn(int'($urandom_range(1, 0)), 1'b0, AW'(a), 8'h00, 1'($urandom));
   endtask

   // Both requesters keep writing; check who wins each slot and the spacing
   task automatic test_simultaneous();
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      int            i0, i1, n, last, cyc, exp_who, who;
      bit            got1;
      do_reset();
      i0 = 0; i1 = 0; n = 0; last = -1;
      a0 = AW'(0); d0 = DW'($urandom);
      a1 = AW'(1); d1 = DW'($urandom);
      drive_req(0, 1'b1, a0, d0);
      drive_req(1, 1'b1, a1, d1);
      for (cyc = 0; cyc < 100 && n < 8; cyc++) begin
         @(posedge clk); #1;
         checks++;
         if ((bus.gnt0 & bus.gnt1) !== 1'b0 || (bus.ack0 & bus.ack1) !== 1'b0) begin
            errors++;
            $display("FAIL sim_exclusive: gnt=%b%b ack=%b%b", bus.gnt0, bus.gnt1, bus.ack0, bus.ack1);
         end
         if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
            who = bus.ack1 ? 1 : 0;
`ifdef RAM32_ARB_RR_EN
            exp_who = n % 2;
`else
            exp_who = 0;
`endif
            checks++;
            if (who !== exp_who) begin
               errors++;
               $display("FAIL sim_winner slot=%0d: got %0d want %0d", n, who, exp_who);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last !== 3) begin
                  errors++;
                  $display("FAIL sim_spacing slot=%0d: got %0d cycles want 3", n, cyc - last);
               end
            end
            last = cyc;
            if (who == 0) begin
               sb[a0] = d0; i0++;
               a0 = AW'(2 * i0); d0 = DW'($urandom);
               drive_req(0, 1'b1, a0, d0);
            end else begin
               sb[a1] = d1; i1++;
               a1 = AW'(2 * i1 + 1); d1 = DW'($urandom);
               drive_req(1, 1'b1, a1, d1);
            end
            n++;
         end
      end
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL sim_timeout: got %0d acks want 8", n);
      end
      // Requester 0 leaves; requester 1 must now be served
      clear_req(0);
      got1 = 1'b0;
      for (int k = 0; k < 10 && !got1; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.ack0 !== 1'b0) begin
            errors++;
            $display("FAIL sim_stray_ack0: got %b want 0", bus.ack0);
         end
         if (bus.ack1 === 1'b1) begin
            got1 = 1'b1;
            sb[a1] = d1;
         end
      end
      checks++;
      if (!got1) begin
         errors++;
         $display("FAIL sim_waiter: ack1 never arrived");
      end
      clear_req(1);
      repeat (2) @(posedge clk);
      #1;
      run_txn(0, 1'b0, a1, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d;
      // Reset during RD of a requester-1 read: no ack, rdata cleared
      drive_req(1, 1'b0, AW'(3), 8'h00);
      @(posedge clk); #1;
      checks++;
      if (bus.gnt1 !== 1'b1 || bus.ram_wr_rd !== 1'b0) begin
         errors++;
         $display("FAIL rmid_rd: gnt1=%b wr_rd=%b want 1 0", bus.gnt1, bus.ram_wr_rd);
      end
      rst = 1'b1;
      clear_req(1);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_rdata = '0;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.ram_wr_rd} !== 5'b0 || bus.rdata !== '0) begin
         errors++;
         $display("FAIL rmid_after: gnt/ack/wr=%b rdata=%h want 0 0",
                  {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.ram_wr_rd}, bus.rdata);
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.ack1 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_no_ack1 k=%0d: got %b want 0", k, bus.ack1);
         end
      end
      // Reset in the WR cycle: the RAM write still lands
      d = DW'($urandom);
      drive_req(0, 1'b1, AW'(7), d);
      @(posedge clk); #1;
      checks++;
      if (bus.ram_wr_rd !== 1'b1) begin
         errors++;
         $display("FAIL rmid_wr: wr_rd=%b want 1", bus.ram_wr_rd);
      end
      rst = 1'b1;
      clear_req(0);
      sb[7] = d;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_rdata = '0;
      checks++;
      if (bus.ack0 !== 1'b0) begin
         errors++;
         $display("FAIL rmid_no_ack0: got %b want 0", bus.ack0);
      end
      run_txn(0, 1'b1, AW'(9), DW'($urandom), 1'b0);
      run_txn(1, 1'b0, AW'(7), 8'h00, 1'b0);
      run_txn(0, 1'b0, AW'(9), 8'h00, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      exp_rdata = '0;
      for (int i = 0; i < 32; i++) sb[i] = '0;
      test_reset();
      test_write_read();
      test_fill_readback();
      test_simultaneous();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
